// File: rtl/bcd_display_arbiter.sv
// Round-robin sequencer that time-shares one combinational binary-to-BCD converter
// between two requesters and keeps the last legal digits for each of them.
module bcd_display_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_val,
  input  logic [4:0] req0_data,
  output logic       req0_rdy,
  input  logic       req1_val,
  input  logic [4:0] req1_data,
  output logic       req1_rdy,
  output logic [4:0] conv_in,
  input  logic [3:0] conv_tens,
  input  logic [3:0] conv_ones,
  output logic [3:0] disp0_tens,
  output logic [3:0] disp0_ones,
  output logic [3:0] disp1_tens,
  output logic [3:0] disp1_ones,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       gnt_q, gnt_d;
  logic       prio_q, prio_d;
  logic [3:0] res_tens_q, res_tens_d;
  logic [3:0] res_ones_q, res_ones_d;
  logic       err_q, err_d;
  logic [3:0] disp_tens_q [2];
  logic [3:0] disp_tens_d [2];
  logic [3:0] disp_ones_q [2];
  logic [3:0] disp_ones_d [2];

  logic [1:0] val_v;
  logic [1:0] rdy_v;
  logic       xfer;
  logic       sel;
  logic       legal;

  assign val_v = {req1_val, req0_val};

  // Grants are only offered from IDLE; rst masks them so outputs sit at reset values.
  always_comb begin
    rdy_v = 2'b00;
    if (state_q == IDLE && !rst) begin
      if (val_v == 2'b11) begin
        rdy_v[prio_q] = 1'b1;
      end else begin
        rdy_v = val_v;
      end
    end
  end

  assign xfer  = |(rdy_v & val_v);
  assign sel   = rdy_v[1];
  assign legal = (res_tens_q <= 4'd3) && (res_ones_q <= 4'd9);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    gnt_d       = gnt_q;
    prio_d      = prio_q;
    res_tens_d  = res_tens_q;
    res_ones_d  = res_ones_q;
    err_d       = err_q;
    disp_tens_d = disp_tens_q;
    disp_ones_d = disp_ones_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          op_d    = sel ? req1_data : req0_data;
          gnt_d   = sel;
          prio_d  = ~sel;
          state_d = CONV;
        end
      end
      CONV: begin
        res_tens_d = conv_tens;
        res_ones_d = conv_ones;
        state_d    = WRITE;
      end
      WRITE: begin
        // An out-of-range digit leaves the display alone and latches the error.
        if (legal) begin
          disp_tens_d[gnt_q] = res_tens_q;
          disp_ones_d[gnt_q] = res_ones_q;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 5'd0;
      gnt_q       <= 1'b0;
      prio_q      <= 1'b0;
      res_tens_q  <= 4'd0;
      res_ones_q  <= 4'd0;
      err_q       <= 1'b0;
      disp_tens_q <= '{default: 4'd0};
      disp_ones_q <= '{default: 4'd0};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      gnt_q       <= gnt_d;
      prio_q      <= prio_d;
      res_tens_q  <= res_tens_d;
      res_ones_q  <= res_ones_d;
      err_q       <= err_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
    end
  end

  assign req0_rdy   = rdy_v[0];
  assign req1_rdy   = rdy_v[1];
  assign conv_in    = (state_q == IDLE) ? 5'd0 : op_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign disp0_tens = disp_tens_q[0];
  assign disp0_ones = disp_ones_q[0];
  assign disp1_tens = disp_tens_q[1];
  assign disp1_ones = disp_ones_q[1];

endmodule
